snitch_ssr_credit_arbiter: RTL and testbench
============================================

Name: snitch_ssr_credit_arbiter

Overview:
Shares one pool of NumCredits credits among NumReq requesters, such as SSR lanes contending for a shared TCDM/FIFO resource. Grants at most one credit per cycle, selected round-robin. Enforces a per-requester in-flight cap. Accepts any number of credit returns per cycle. A drain sequencer quiesces the pool so it can be reconfigured.

Parameters:
NumReq, 4, number of requesters (>=2)
NumCredits, 8, total credits in the shared pool (>=1)
MaxInflight, 4, max credits one requester may hold (1..NumCredits)
Derived (do not override): PoolW = $clog2(NumCredits)+1; InfW = $clog2(MaxInflight)+1; IdxW = $clog2(NumReq)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_valid_i  in  NumReq  requester i wants one credit
req_ready_o  out  NumReq  one-hot-or-zero grant; handshake = valid & ready
ret_i  in  NumReq  requester i returns one credit this cycle
init_i  in  1  synchronous soft reinit; highest priority
drain_i  in  1  level; request quiesce
drained_o  out  1  pool full and nothing in flight while draining
credit_o  out  PoolW  current free-pool count
inflight_o  out  NumReq*InfW  per-requester held count, requester i at [i*InfW +: InfW]
err_o  out  1  sticky: a credit was returned with inflight==0

Behaviour:
- Reset (rst_i high, asynchronous):
  - credit_o=NumCredits; all inflight=0; rr pointer=0; state=RUN; err_o=0; drained_o=0.
  - req_ready_o=0 while rst_i is high.
- Eligibility: requester i is eligible when req_valid_i[i] & inflight[i]<MaxInflight & credit_o>0 & state==RUN & !init_i.
- Arbitration:
  - Combinational, same cycle.
  - Winner = first eligible index at or after the pointer, wrapping modulo NumReq.
  - req_ready_o[winner]=1; all other bits 0.
  - req_ready_o may depend on req_valid_i. Valid must not depend on ready.
- Pointer update: on a handshake, pointer <= winner+1, wrapping NumReq-1 -> 0. Otherwise unchanged. An ineligible requester is skipped and does not block others.
- Pool arithmetic per cycle: credit_d = credit_q - g + r.
  - g = 1 if any handshake, else 0.
  - r = popcount of accepted returns.
  - Widths are sized so the pool never exceeds NumCredits.
- Return acceptance:
  - ret_i[i] with inflight[i]>0 is accepted.
  - ret_i[i] with inflight[i]==0 is ignored (no count change) and sets err_o.
- Per requester: inflight_d = inflight_q + grant_i - accepted_ret_i.
  - Grant plus return on the same requester in the same cycle leaves inflight unchanged.
  - Exception: a return on inflight==0 together with a grant yields inflight=1 and sets err_o.
- Credit freed the same cycle: a return is not visible to eligibility until the next cycle, so eligibility uses the registered credit_q. With credit_q==0 and a return arriving, no grant that cycle.
- FSM (state register):
  - RUN: grants enabled. drain_i=1 -> DRAIN.
  - DRAIN: no grants; returns still accepted. When credit_q==NumCredits and all inflight==0 -> DRAINED.
  - DRAINED: drained_o=1; no grants. drain_i=0 -> RUN.
  - drain_i deasserted while in DRAIN -> RUN immediately, and grants resume next cycle.
  - drained_o is registered and high only in DRAINED.
- init_i (synchronous soft reset, any state): next cycle credit=NumCredits, inflight all 0, pointer=0, err_o=0, state=RUN. req_ready_o=0 and returns are ignored in the init_i cycle.
- Invariant assertions:
  - credit_q + sum(inflight) == NumCredits at all times outside reset/init.
  - Never more than one req_ready_o bit set.
  - No grant when credit_q==0.

Test Plan:
- Reset then all 4 requesters valid continuously, no returns -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; credit_o reaches 0 after 8 cycles; inflight=2 each; ready all 0 afterwards.
- Only requester 2 valid, MaxInflight=4 -> 4 grants in cycles 1-4, then ready_o[2]=0; credit_o=4; one ret_i[2] -> next cycle grant resumes.
- Pool empty (credit_o=0); ret_i=4'b1011 in one cycle (each with inflight>0) -> next cycle credit_o=3; no grant in the return cycle.
- Same-cycle grant and return on requester 1 (inflight 2) -> inflight stays 2, credit_o unchanged.
- ret_i[3] with inflight[3]==0 -> err_o=1 sticky, counts unchanged; init_i pulse -> err_o=0, credit_o=8, pointer 0.
- 5 credits outstanding, drain_i=1 -> no grants; after the 5th return, drained_o=1 the following cycle; drain_i=0 -> RUN and grants resume.
- rst_i asserted mid-traffic with no clock edge -> outputs immediately at their reset values (credit_o=8, ready=0).

Source files
------------

// File: rtl/snitch_ssr_credit_arbiter.sv
// rtl/snitch_ssr_credit_arbiter.sv - round-robin shared credit pool with per-requester cap and drain sequencer
module snitch_ssr_credit_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned NumCredits  = 8,
    parameter int unsigned MaxInflight = 4,
    localparam int unsigned PoolW      = $clog2(NumCredits) + 1,
    localparam int unsigned InfW       = $clog2(MaxInflight) + 1,
    localparam int unsigned IdxW       = $clog2(NumReq)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumReq-1:0]        req_valid_i,
    output logic [NumReq-1:0]        req_ready_o,
    input  logic [NumReq-1:0]        ret_i,
    input  logic                     init_i,
    input  logic                     drain_i,
    output logic                     drained_o,
    output logic [PoolW-1:0]         credit_o,
    output logic [NumReq*InfW-1:0]   inflight_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StDrained = 2'd2
    } state_e;

    localparam logic [PoolW-1:0] PoolFull = PoolW'(NumCredits);
    localparam logic [InfW-1:0]  InfCap   = InfW'(MaxInflight);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumReq - 1);

    state_e             state_q, state_d;
    logic [PoolW-1:0]   credit_q, credit_d;
    logic [InfW-1:0]    inflight_q [NumReq];
    logic [InfW-1:0]    inflight_d [NumReq];
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic               err_q, err_d;
    logic               drained_q, drained_d;

    logic [NumReq-1:0]  eligible;
    logic [NumReq-1:0]  grant;
    logic [NumReq-1:0]  ret_acc;
    logic [IdxW:0]      ret_cnt;
    logic               ret_bad;
    logic               found;
    logic [IdxW-1:0]    winner;
    logic               pool_idle;

    // Eligibility uses registered credit so a same-cycle return cannot fund a grant
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (inflight_q[i] < InfCap) && (credit_q != '0)
                          && (state_q == StRun) && !init_i && !rst_i;
        end
    end

    // Round-robin pick: first eligible index at or after the pointer, wrapping
    always_comb begin
        logic [IdxW:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = {1'b0, ptr_q} + (IdxW+1)'(k);
            if (idx >= (IdxW+1)'(NumReq)) begin
                idx = idx - (IdxW+1)'(NumReq);
            end
            if (!found && eligible[idx[IdxW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IdxW-1:0];
            end
        end
        grant = '0;
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    assign req_ready_o = grant;

    // Returns only count against a requester that actually holds a credit
    always_comb begin
        ret_acc   = '0;
        ret_cnt   = '0;
        ret_bad   = 1'b0;
        pool_idle = (credit_q == PoolFull);
        for (int i = 0; i < NumReq; i++) begin
            ret_acc[i] = ret_i[i] && (inflight_q[i] != '0) && !init_i;
            ret_cnt    = ret_cnt + (IdxW+1)'(ret_acc[i]);
            if (ret_i[i] && (inflight_q[i] == '0)) begin
                ret_bad = 1'b1;
            end
            if (inflight_q[i] != '0) begin
                pool_idle = 1'b0;
            end
        end
    end

    // Next-state for pool, per-requester counts, pointer, error and drain FSM
    always_comb begin
        credit_d = credit_q - PoolW'(found) + PoolW'(ret_cnt);
        for (int i = 0; i < NumReq; i++) begin
            inflight_d[i] = inflight_q[i] + InfW'(grant[i]) - InfW'(ret_acc[i]);
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (winner == LastIdx) ? '0 : winner + 1'b1;
        end
        err_d = err_q | ret_bad;

        state_d = state_q;
        case (state_q)
            StRun:     if (drain_i) state_d = StDrain;
            StDrain: begin
                if (!drain_i) begin
                    state_d = StRun;
                end else if (pool_idle) begin
                    state_d = StDrained;
                end
            end
            StDrained: if (!drain_i) state_d = StRun;
            default:   state_d = StRun;
        endcase

        if (init_i) begin
            credit_d = PoolFull;
            for (int i = 0; i < NumReq; i++) begin
                inflight_d[i] = '0;
            end
            ptr_d   = '0;
            err_d   = 1'b0;
            state_d = StRun;
        end
        drained_d = (state_d == StDrained);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StRun;
            credit_q  <= PoolFull;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            drained_q <= 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                inflight_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            drained_q <= drained_d;
            for (int i = 0; i < NumReq; i++) begin
                inflight_q[i] <= inflight_d[i];
            end
        end
    end

    // Flatten per-requester counts onto the output bus
    always_comb begin
        inflight_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            inflight_o[i*InfW +: InfW] = inflight_q[i];
        end
    end

    assign credit_o  = credit_q;
    assign err_o     = err_q;
    assign drained_o = drained_q;

`ifndef SYNTHESIS
    logic [PoolW:0] inflight_sum;

    // Credits are conserved between the pool and the holders
    always_comb begin
        inflight_sum = '0;
        for (int i = 0; i < NumReq; i++) begin
            inflight_sum = inflight_sum + (PoolW+1)'(inflight_q[i]);
        end
    end

    a_conserve: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, credit_q} + inflight_sum) == (PoolW+1)'(NumCredits));
    a_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_no_empty_grant: assert property (@(posedge clk_i) disable iff (rst_i)
        !((credit_q == '0) && (|req_ready_o)));
`endif

endmodule

// File: tb/tb_snitch_ssr_credit_arbiter.sv
// tb/tb_snitch_ssr_credit_arbiter.sv - directed self-checking bench for snitch_ssr_credit_arbiter
module tb_snitch_ssr_credit_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  ret_i;
    logic        init_i;
    logic        drain_i;
    logic        drained_o;
    logic [3:0]  credit_o;
    logic [11:0] inflight_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    snitch_ssr_credit_arbiter #(
        .NumReq      (4),
        .NumCredits  (8),
        .MaxInflight (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .ret_i       (ret_i),
        .init_i      (init_i),
        .drain_i     (drain_i),
        .drained_o   (drained_o),
        .credit_o    (credit_o),
        .inflight_o  (inflight_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 4'hF;
        ret_i       = 4'h0;
        init_i      = 1'b0;
        drain_i     = 1'b0;

        #12;
        check_eq("rst_ready",    32'(req_ready_o), 32'h0);
        check_eq("rst_credit",   32'(credit_o),    32'd8);
        check_eq("rst_inflight", 32'(inflight_o),  32'h0);
        check_eq("rst_err",      32'(err_o),       32'h0);
        check_eq("rst_drained",  32'(drained_o),   32'h0);

        tick();
        rst_i = 1'b0;

        // All requesters valid: strict rotation until the pool is empty
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq($sformatf("rr_grant%0d", k), 32'(req_ready_o), 32'(4'b0001 << (k % 4)));
            tick();
        end
        check_eq("rr_credit",   32'(credit_o),   32'd0);
        check_eq("rr_inflight", 32'(inflight_o), 32'h492);
        #1;
        check_eq("rr_empty_ready", 32'(req_ready_o), 32'h0);

        // Empty pool, three returns at once; no grant in the return cycle
        ret_i = 4'b1011;
        #1;
        check_eq("ret_nogrant", 32'(req_ready_o), 32'h0);
        tick();
        ret_i = 4'h0;
        check_eq("ret_credit",   32'(credit_o),   32'd3);
        check_eq("ret_inflight", 32'(inflight_o), 32'h289);
        #1;
        check_eq("ret_regrant", 32'(req_ready_o), 32'b0001);

        // Same-cycle grant and return on requester 1
        req_valid_i = 4'b0010;
        #1;
        check_eq("gr1_ready", 32'(req_ready_o), 32'b0010);
        tick();
        check_eq("gr1_credit", 32'(credit_o), 32'd2);
        ret_i = 4'b0010;
        #1;
        check_eq("gr1_both_ready", 32'(req_ready_o), 32'b0010);
        tick();
        ret_i       = 4'h0;
        req_valid_i = 4'h0;
        check_eq("gr1_both_credit",   32'(credit_o),   32'd2);
        check_eq("gr1_both_inflight", 32'(inflight_o), 32'h291);

        // Init cycle: no grant, returns ignored
        init_i      = 1'b1;
        req_valid_i = 4'hF;
        ret_i       = 4'hF;
        #1;
        check_eq("init_ready", 32'(req_ready_o), 32'h0);
        tick();
        init_i      = 1'b0;
        ret_i       = 4'h0;
        req_valid_i = 4'h0;
        check_eq("init_credit",   32'(credit_o),   32'd8);
        check_eq("init_inflight", 32'(inflight_o), 32'h0);
        check_eq("init_err",      32'(err_o),      32'h0);

        // Return with nothing held: sticky error, counts untouched
        ret_i = 4'b1000;
        tick();
        ret_i = 4'h0;
        check_eq("err_set",      32'(err_o),      32'h1);
        check_eq("err_credit",   32'(credit_o),   32'd8);
        check_eq("err_inflight", 32'(inflight_o), 32'h0);
        tick();
        check_eq("err_sticky", 32'(err_o), 32'h1);

        // Move pointer off zero, then init clears error and pointer
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = 4'h0;
        check_eq("ptr_credit", 32'(credit_o), 32'd7);
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        check_eq("init2_err",      32'(err_o),      32'h0);
        check_eq("init2_credit",   32'(credit_o),   32'd8);
        check_eq("init2_inflight", 32'(inflight_o), 32'h0);
        req_valid_i = 4'hF;
        #1;
        check_eq("init2_ptr", 32'(req_ready_o), 32'b0001);

        // Single requester hits its in-flight cap
        req_valid_i = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("cap_grant%0d", k), 32'(req_ready_o), 32'b0100);
            tick();
        end
        #1;
        check_eq("cap_block",    32'(req_ready_o), 32'h0);
        check_eq("cap_credit",   32'(credit_o),    32'd4);
        check_eq("cap_inflight", 32'(inflight_o),  32'h100);
        ret_i = 4'b0100;
        #1;
        check_eq("cap_ret_block", 32'(req_ready_o), 32'h0);
        tick();
        ret_i = 4'h0;
        check_eq("cap_ret_credit", 32'(credit_o), 32'd5);
        #1;
        check_eq("cap_resume", 32'(req_ready_o), 32'b0100);
        tick();
        check_eq("cap_resume_credit", 32'(credit_o), 32'd4);

        // Five credits out, then drain to full
        req_valid_i = 4'b0001;
        #1;
        check_eq("pre_drain_grant", 32'(req_ready_o), 32'b0001);
        tick();
        check_eq("pre_drain_credit", 32'(credit_o), 32'd3);
        req_valid_i = 4'h0;
        drain_i     = 1'b1;
        tick();
        req_valid_i = 4'hF;
        #1;
        check_eq("drain_nogrant", 32'(req_ready_o), 32'h0);
        ret_i = 4'b0101;
        tick();
        check_eq("drain_credit5", 32'(credit_o), 32'd5);
        ret_i = 4'b0100;
        tick();
        tick();
        tick();
        ret_i = 4'h0;
        check_eq("drain_full",      32'(credit_o),   32'd8);
        check_eq("drain_inflight",  32'(inflight_o), 32'h0);
        check_eq("drain_not_yet",   32'(drained_o),  32'h0);
        #1;
        check_eq("drain_nogrant2", 32'(req_ready_o), 32'h0);
        tick();
        check_eq("drained_set", 32'(drained_o), 32'h1);
        #1;
        check_eq("drained_nogrant", 32'(req_ready_o), 32'h0);
        drain_i = 1'b0;
        tick();
        check_eq("drained_clr", 32'(drained_o), 32'h0);
        #1;
        check_eq("run_resume", 32'(req_ready_o), 32'b0010);

        // Drain withdrawn while still draining: back to RUN next cycle
        req_valid_i = 4'h0;
        drain_i     = 1'b1;
        tick();
        req_valid_i = 4'hF;
        #1;
        check_eq("abort_nogrant", 32'(req_ready_o), 32'h0);
        drain_i = 1'b0;
        tick();
        check_eq("abort_drained", 32'(drained_o), 32'h0);
        #1;
        check_eq("abort_resume", 32'(req_ready_o), 32'b0010);

        // Asynchronous reset mid-traffic
        tick();
        tick();
        check_eq("mid_credit", 32'(credit_o), 32'd6);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("async_credit",   32'(credit_o),    32'd8);
        check_eq("async_ready",    32'(req_ready_o), 32'h0);
        check_eq("async_inflight", 32'(inflight_o),  32'h0);
        tick();
        rst_i = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(req_ready_o), 32'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
